// File: rtl/ext_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ext_intr_ctrl
//  Purpose  : External interrupt front-end. Synchronises sources, latches
//             edge/level pending events, arbitrates by fixed priority and
//             pulses intr until the control unit acknowledges the claim.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_intr_ctrl #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 ID_W      = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
  parameter int                 TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_enable,
  input  logic               cu_intr_ack,
  output logic               intr,
  output logic [ID_W-1:0]    intr_id,
  output logic [31:0]        intr_cause,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               busy
);

  localparam logic [31:0] c_MEI_CAUSE = 32'h8000000B;
  localparam bit          c_TO_EN     = (TIMEOUT != 0);
  localparam logic [15:0] c_TO_LAST   = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_SRC-1:0] r_s1;
  logic [NUM_SRC-1:0] r_s2;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pend_edge;
  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_win_oh;
  logic [NUM_SRC-1:0] w_claim_clr;
  logic [ID_W-1:0]    w_win_id;
  logic               w_claim;
  logic [15:0]        r_cnt;
  logic [15:0]        w_cnt_nxt;
  logic [ID_W-1:0]    r_id;
  logic               r_intr;
  logic               r_busy;
  logic [31:0]        r_cause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= irq_src;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Level sources bypass the latch and follow the synchronised line directly.
  assign w_pending = (r_pend_edge & EDGE_MASK) | (r_s2 & ~EDGE_MASK);
  assign w_cand    = w_pending & irq_enable;
  assign w_win_oh  = w_cand & (~w_cand + NUM_SRC'(1));

  always_comb begin
    w_win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win_id = ID_W'(i);
    end
  end

  assign w_claim_clr = w_claim ? w_win_oh : '0;

  // A new rising edge on the claim cycle re-arms the bit (set wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_edge <= '0;
    end else begin
      r_pend_edge <= ((r_pend_edge & ~w_claim_clr) | (r_s2 & ~r_prev)) & EDGE_MASK;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_claim     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_cand) begin
          w_claim     = 1'b1;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cu_intr_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_WAIT: begin
        if (cu_intr_ack) begin
          w_state_nxt = S_IDLE;
        end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
          w_state_nxt = S_PULSE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_id    <= '0;
      r_intr  <= 1'b0;
      r_busy  <= 1'b0;
      r_cause <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_claim) r_id <= w_win_id;
      r_intr  <= (w_state_nxt == S_PULSE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_cause <= (w_state_nxt != S_IDLE) ? c_MEI_CAUSE : 32'd0;
    end
  end

  assign intr        = r_intr;
  assign intr_id     = r_id;
  assign intr_cause  = r_cause;
  assign irq_pending = w_pending;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/ext_intr_ctrl.md
# ext_intr_ctrl

External interrupt front-end for the single-cycle interrupt core. It synchronises up to NUM_SRC asynchronous interrupt lines and latches edge or level events as pending. It arbitrates enabled pending sources by fixed priority and drives the one-cycle `intr` pulse that sets MEIP (mip[11]) in the CSR unit. It then holds the claimed source ID until the control unit returns `cu_intr_ack`, and re-pulses if the acknowledge does not arrive within a timeout.

## Interface
- `NUM_SRC`, 8 — number of external interrupt sources (2..32).
- `ID_W`, 3 — width of source ID; equals ceil(log2(NUM_SRC)).
- `EDGE_MASK`, 8'hFF — per source: 1 = rising-edge sensitive, 0 = level sensitive.
- `TIMEOUT`, 255 — WAIT cycles before re-pulsing `intr`; 0 disables re-pulse. Fits in 16 bits.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset; clears all state.
- `irq_src`  in  NUM_SRC  raw asynchronous interrupt lines.
- `irq_enable`  in  NUM_SRC  per-source enable mask; quasi-static, sampled directly.
- `cu_intr_ack`  in  1  control unit has taken the trap for the current claim.
- `intr`  out  1  one-cycle request pulse to the CSR unit (sets mip[11]).
- `intr_id`  out  ID_W  ID of the claimed source; valid while `busy`.
- `intr_cause`  out  32  32'h8000000B while `busy`, else 0.
- `irq_pending`  out  NUM_SRC  pending vector, unmasked.
- `busy`  out  1  a claim is outstanding (state PULSE or WAIT).

## Operation
- Each source passes through a 2-flop synchroniser (`s1`→`s2`) and an edge-history flop (`prev`). All three reset to 0.
- Edge sources: pending[i] is set when `s2 & ~prev` and cleared when source i is claimed. If a set and a claim-clear hit the same edge, set wins.
- Level sources: pending[i] equals `s2` and is never cleared by a claim.
- Candidate vector is `pending & irq_enable`. The lowest index wins.
- FSM states IDLE, PULSE, WAIT; reset to IDLE.
- IDLE: if the candidate vector is non-zero, go to PULSE, latch the winner into `intr_id`, and clear its pending bit if it is an edge source. Otherwise stay in IDLE.
- PULSE lasts exactly one cycle with `intr`=1.
  - `cu_intr_ack`=1 → IDLE.
  - Otherwise → WAIT, with the timeout counter cleared to 0.
- WAIT:
  - `cu_intr_ack`=1 → IDLE. Ack has priority over the timeout.
  - Counter reaches TIMEOUT−1 with TIMEOUT≠0 → PULSE again with the same `intr_id`. No re-arbitration and no pending change.
  - Otherwise the counter increments.
- `cu_intr_ack` in IDLE is ignored.
- Changing `irq_enable` during PULSE or WAIT does not affect the outstanding claim.
- Returning to IDLE allows arbitration on the next edge. A still-asserted level source is re-claimed immediately.
- `intr_id` holds its last value in IDLE. Consumers use it only while `busy`=1.

## Timing
- Reset values: `intr`=0, `intr_id`=0, `intr_cause`=0, `irq_pending`=0, `busy`=0; counter=0.
- Asserting `reset` in any state returns to IDLE at once and drops `intr` asynchronously. No pulse is owed after release.
- Latency from an `irq_src` rise first sampled at edge E0:
  - `s2`=1 after E1.
  - pending=1 after E2.
  - `intr`=1 during the cycle after E3 (registered).
- `intr` is never high for two consecutive cycles. A re-pulse is separated from the previous pulse by at least TIMEOUT cycles of WAIT.
- After ack at edge A, the earliest next `intr` is the cycle after A+1 (IDLE arbitrates during the cycle after A).
- An edge source held high through reset produces a pending edge after release, because `prev` resets to 0.
- `busy` and `intr_cause` are registered and change on the same edges as the state.

## Test plan
- Single edge: rise on `irq_src[5]` with enable=8'hFF. Expect `intr` high for exactly one cycle 3 cycles after first sampling, `intr_id`=5, `intr_cause`=0x8000000B, `irq_pending[5]` cleared on the claim edge. Ack 4 cycles later → `busy`=0.
- Priority: rises on sources 6 and 2 in the same cycle. Expect claim 2 first, with pending=8'h40 after the claim. After ack, claim 6 two cycles later.
- Masking: source 3 pending with `irq_enable[3]`=0. Expect no `intr` and `irq_pending`=8'h08 held. Set enable → `intr` on the next cycle with `intr_id`=3.
- Timeout: TIMEOUT=4 and no ack. Expect `intr` pulses exactly 5 cycles apart, `intr_id` unchanged. Ack in the same cycle the counter expires → IDLE, no re-pulse.
- Level source: EDGE_MASK bit 0 = 0, `irq_src[0]` held high. After each ack, a new claim of ID 0 occurs two cycles later. Drop the line → no further pulses after the synchroniser delay.
- Reset mid-WAIT: assert `reset` for one cycle. Expect `busy`=0, `intr`=0, `irq_pending`=0 immediately. A source held high through reset is re-claimed 3 cycles after release.
